// File: rtl/uart_cfg_sequencer_if.sv
// uart_cfg_sequencer_if: register-write port between the config sequencer and the UART receive processor
interface uart_cfg_sequencer_if;
   logic       valid;
   logic [3:0] address;
   logic [3:0] data;
   logic       ack;
   modport master (output valid, address, data, input ack);
   modport slave (input valid, address, data, output ack);
endinterface

// File: rtl/uart_cfg_sequencer.sv
// uart_cfg_sequencer: latches a line configuration and pushes it as four acked, retried register writes
module uart_cfg_sequencer #(
   parameter int unsigned TIMEOUT   = 15,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_start_i,
   input  logic                        cfg_parity_en_i,
   input  logic                        cfg_parity_odd_i,
   input  logic                        cfg_stop2_i,
   input  logic [3:0]                  cfg_len_i,
   uart_cfg_sequencer_if.master        cfg_if,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, GAP, FINISH} state_e;
   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [2:0] retry_q, retry_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] flags_q, flags_d;
   logic [3:0] len_q, len_d;
   logic       err_q, err_d;
   logic       len_ok, expired;
   assign len_ok  = cfg_len_i >= 4'd5 && cfg_len_i <= 4'd9;
   // the cycle in which the counter would reach TIMEOUT is the last ISSUE cycle
   assign expired = cnt_q == 8'(TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         retry_q <= '0;
         cnt_q   <= '0;
         flags_q <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         retry_q <= retry_d;
         cnt_q   <= cnt_d;
         flags_q <= flags_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      retry_d = retry_q;
      cnt_d   = cnt_q;
      flags_d = flags_q;
      len_d   = len_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (cfg_start_i) begin
            if (!len_ok) err_d = 1'b1;
            else begin
               err_d   = 1'b0;
               flags_d = {1'b0, cfg_stop2_i, cfg_parity_odd_i, cfg_parity_en_i};
               len_d   = cfg_len_i;
               idx_d   = '0;
               retry_d = '0;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: if (cfg_if.ack) begin
            state_d = idx_q == 2'd3 ? FINISH : GAP;
            idx_d   = idx_q + 2'd1;
            retry_d = '0;
         end else if (expired) begin
            if (retry_q < 3'(MAX_RETRY)) begin
               retry_d = retry_q + 3'd1;
               state_d = GAP;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end else cnt_d = cnt_q + 8'd1;
         GAP: begin
            cnt_d   = '0;
            state_d = ISSUE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      cfg_if.valid   = state_q == ISSUE;
      cfg_if.address = cfg_if.valid ? 4'd9 + {2'b00, idx_q} : 4'd0;
      cfg_if.data    = !cfg_if.valid ? 4'd0 : idx_q == 2'd3 ? len_q - 4'd5 : {flags_q[idx_q], 3'b000};
      busy_o         = state_q == ISSUE || state_q == GAP;
      done_o         = state_q == FINISH;
      err_o          = err_q;
   end
endmodule

// File: doc/uart_cfg_sequencer.md
# uart_cfg_sequencer

Configuration sequencer for the UART receive processor. On a single start request it latches a complete line configuration (parity enable, parity type, stop bits, frame length) and drives the processor's `valid`/`address`/`data`/`ack` register-write port through four ordered writes. Each write waits for `ack`, is retried on timeout, and the block reports completion or failure. It sits between the host/control logic and the UART receive path, and is the only master of that config port.

## Interface
- `TIMEOUT`, 15: cycles `valid` may stay high without `ack` before the write is abandoned and retried (1..255).
- `MAX_RETRY`, 3: retries allowed per write after the first attempt (0..7).

- `clk`  in  1  block clock; `ack` is synchronous to it (any crossing is done outside this block).
- `rst`  in  1  synchronous, active-high reset.
- `cfg_start`  in  1  one-cycle request; samples the `cfg_*` inputs.
- `cfg_parity_en`  in  1  parity enable.
- `cfg_parity_odd`  in  1  1 = odd parity, 0 = even.
- `cfg_stop2`  in  1  1 = two stop bits.
- `cfg_len`  in  4  data bits per frame; legal range 5..9.
- `valid`  out  1  write strobe to the UART processor.
- `address`  out  4  register address.
- `data`  out  4  register data.
- `ack`  in  1  write accepted by the UART processor.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse when all four writes are acknowledged.
- `err`  out  1  sticky failure flag; cleared by the next accepted `cfg_start` or by `rst`.

## Operation
- States:
  - IDLE: waiting for `cfg_start`.
  - ISSUE: `valid` = 1, waiting for `ack` or timeout.
  - GAP: `valid` = 0 for exactly one cycle.
  - FINISH: `done` = 1 for one cycle, then IDLE.
- Write order, with the configuration latched at `cfg_start`:
  - idx 0: `address` 4'b1001, `data` = {`parity_en`, 3'b000}.
  - idx 1: `address` 4'b1010, `data` = {`parity_odd`, 3'b000}.
  - idx 2: `address` 4'b1011, `data` = {`stop2`, 3'b000}.
  - idx 3: `address` 4'b1100, `data` = `cfg_len` − 5 (range 0..4, 4-bit unsigned).
- IDLE with `cfg_start` = 1:
  - If `cfg_len` < 5 or `cfg_len` > 9: `err` is set on the next cycle, no write is issued, `done` is not pulsed, and the block stays in IDLE.
  - Otherwise: `err` is cleared, the config is latched, idx = 0, retry = 0, timeout counter = 0, go to ISSUE.
- ISSUE:
  - `ack` = 1 at a clock edge accepts the write. If idx = 3, go to FINISH; else idx+1, retry = 0, go to GAP.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT`:
    - If retry < `MAX_RETRY`: retry+1, go to GAP, then reissue the same idx.
    - Otherwise: set `err`, go to IDLE.
- GAP: counter = 0, then go to ISSUE.
- Ignored inputs:
  - `cfg_start` while `busy` = 1 (it is not queued).
  - `ack` while `valid` = 0.
- `address`/`data` hold stable for the whole ISSUE period and are 0 in IDLE.

## Timing
- Reset values: `valid` 0, `address` 0, `data` 0, `busy` 0, `done` 0, `err` 0, state IDLE. Reset mid-sequence drops `valid` at the same edge, the sequence is aborted, and no `done` pulse is produced.
- `cfg_start` sampled at edge N gives `valid` = 1 with address 9 from cycle N+1. `busy` = 1 from N+1 until FINISH.
- `ack` high at the edge in a cycle where `valid` = 1 gives `valid` = 0 in the next cycle (GAP). The next write starts one cycle later.
- With immediate ack: `done` asserts at cycle N+8 (4 ISSUE + 3 GAP cycles). `busy` = 0 during the `done` cycle.
- Timeout: `valid` is high for exactly `TIMEOUT` cycles, then one GAP cycle, then the retry. If `ack` arrives in the same cycle the counter reaches `TIMEOUT`, the ack wins.
- Failure: `err` rises and `busy` falls in the cycle after the last timeout. A failed write reaches `TIMEOUT`×(`MAX_RETRY`+1) ISSUE cycles in total.
- `done` and `err` are never set by the same sequence.

## Test plan
- `cfg_start` with en=1, odd=1, stop2=0, len=8; ack returned in the same cycle each time -> writes (9,8), (10,8), (11,0), (12,3); `done` pulses at N+8; `err` = 0.
- Same config, ack delayed 5 cycles on idx 2 -> `valid`/`address` 11 held for 6 cycles; sequence completes; `done` at N+13.
- No ack on idx 1 with defaults -> 4 attempts of 15 cycles each, each separated by one GAP; `err` = 1, `busy` = 0; address 12 is never driven.
- `cfg_len` = 4 and then `cfg_len` = 10 -> `err` = 1, `valid` never asserts. A following legal `cfg_start` clears `err`.
- Second `cfg_start` during idx 2 and `ack` pulses while in GAP -> both ignored; write order and timing are unchanged.
- `rst` asserted while in ISSUE on idx 1 -> next cycle all outputs are 0 and no `done`. A fresh `cfg_start` restarts from address 9.
